sdram_readback_checker: RTL

SDRAM_READBACK_CHECKER -- requirements
Module: sdram_readback_checker

---
 rtl/sdram_readback_checker.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/sdram_readback_checker.sv
// -----------------------------------------------------------------------------
// sdram_readback_checker
//
// Purpose:
//   Walks NUM_WORDS sequential word addresses through an SDRAM controller's
//   request/ready handshake as reads. Each returned word is compared with
//   BASE_DATA + address (modulo 2^32). It reports a mismatch count that
//   saturates at 16'hFFFF. It also records the address and data of the first
//   mismatch, and flags pass when a full pass has finished with no mismatches.
//
// Ports:
//   clk            - single clock, all logic on rising edge
//   rst            - synchronous active-high reset
//   start          - one-cycle pulse; starts (or restarts) a pass from IDLE/DONE
//   o_valid        - read request valid toward the controller
//   i_ready        - controller completion; transfer = o_valid && i_ready
//   o_addr         - word address of the current request
//   o_wdata        - always 0 (read-only requester)
//   o_wstrb        - always 0 (read-only requester)
//   i_rdata        - read data, valid in the transfer cycle
//   busy           - pass in progress (state RUN)
//   done           - pass finished
//   pass           - pass finished with zero mismatches
//   err_count      - saturating mismatch count
//   first_err_addr - address of the first mismatch in the pass
//   first_err_data - data received at the first mismatch
// -----------------------------------------------------------------------------
module sdram_readback_checker #(
   parameter int unsigned NUM_WORDS = 1024,
   parameter logic [31:0] BASE_DATA = 32'h11111111
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        o_valid,
   input  logic        i_ready,
   output logic [31:0] o_addr,
   output logic [31:0] o_wdata,
   output logic [3:0]  o_wstrb,
   input  logic [31:0] i_rdata,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [15:0] err_count,
   output logic [31:0] first_err_addr,
   output logic [31:0] first_err_data
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [31:0] LAST_ADDR = 32'(NUM_WORDS - 1);

   state_t      r_state;
   logic        r_valid;
   logic        r_busy;
   logic        r_done;
   logic        r_pass;
   logic [31:0] r_addr;
   logic [15:0] r_err_count;
   logic [31:0] r_first_err_addr;
   logic [31:0] r_first_err_data;

   logic        w_xfer;
   logic        w_mismatch;
   logic        w_last;
   logic [15:0] w_err_inc;
   logic [15:0] w_err_after;

   // The request is only ever valid in RUN, so i_ready outside RUN is ignored.
   assign w_xfer      = (r_state == ST_RUN) && i_ready;
   assign w_mismatch  = (i_rdata != (BASE_DATA + r_addr));
   assign w_last      = (r_addr == LAST_ADDR);
   assign w_err_inc   = (r_err_count == 16'hFFFF) ? r_err_count : r_err_count + 16'd1;
   // Count including the compare of this cycle; pass is derived from this on
   // the last transfer so the final word is not missed.
   assign w_err_after = w_mismatch ? w_err_inc : r_err_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state          <= ST_IDLE;
         r_valid          <= 1'b0;
         r_busy           <= 1'b0;
         r_done           <= 1'b0;
         r_pass           <= 1'b0;
         r_addr           <= '0;
         r_err_count      <= '0;
         r_first_err_addr <= '0;
         r_first_err_data <= '0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               // Results are held here until a new start clears them.
               if (start) begin
                  r_state          <= ST_RUN;
                  r_valid          <= 1'b1;
                  r_busy           <= 1'b1;
                  r_done           <= 1'b0;
                  r_pass           <= 1'b0;
                  r_addr           <= '0;
                  r_err_count      <= '0;
                  r_first_err_addr <= '0;
                  r_first_err_data <= '0;
               end
            end

            ST_RUN: begin
               // start is deliberately not looked at here.
               if (w_xfer) begin
                  if (w_mismatch) begin
                     r_err_count <= w_err_inc;
                     // The count never returns to zero within a pass, so zero
                     // identifies the first mismatch.
                     if (r_err_count == 16'd0) begin
                        r_first_err_addr <= r_addr;
                        r_first_err_data <= i_rdata;
                     end
                  end
                  if (w_last) begin
                     r_state <= ST_DONE;
                     r_valid <= 1'b0;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_pass  <= (w_err_after == 16'd0);
                  end else begin
                     r_addr <= r_addr + 32'd1;
                  end
               end
            end

            default: begin
               r_state <= ST_IDLE;
               r_valid <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_valid        = r_valid;
   assign o_addr         = r_addr;
   assign o_wdata        = '0;
   assign o_wstrb        = '0;
   assign busy           = r_busy;
   assign done           = r_done;
   assign pass           = r_pass;
   assign err_count      = r_err_count;
   assign first_err_addr = r_first_err_addr;
   assign first_err_data = r_first_err_data;

endmodule
